// File: rtl/dtw_hit_selector.sv
// dtw_hit_selector: tracks min / second-min cost and min position over one scan.
// Optional margin match term enabled by defining DTW_HIT_MARGIN_EN.
module dtw_hit_selector #(
    parameter int DWIDTH = 32,
    parameter int PWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       ref_len,
    input  logic [DWIDTH-1:0] threshold,
`ifdef DTW_HIT_MARGIN_EN
    input  logic [DWIDTH-1:0] margin,
`endif
    output logic              running,
    output logic              src_fifo_rden,
    input  logic              src_fifo_empty,
    input  logic [DWIDTH-1:0] src_fifo_data,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [DWIDTH-1:0] result_cost,
    output logic [PWIDTH-1:0] result_pos,
    output logic [DWIDTH-1:0] result_cost2,
    output logic              result_match
);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    localparam logic [DWIDTH-1:0] ONES = '1;

    state_t            state_q;
    state_t            state_d;
    logic [PWIDTH-1:0] lat_len;
    logic [PWIDTH-1:0] rd_cnt;
    logic [PWIDTH-1:0] rx_cnt;
    logic [PWIDTH-1:0] pos_q;
    logic [DWIDTH-1:0] lat_thr;
    logic [DWIDTH-1:0] min_q;
    logic [DWIDTH-1:0] min2_q;
`ifdef DTW_HIT_MARGIN_EN
    logic [DWIDTH-1:0] lat_margin;
`endif
    logic              data_vld;
    logic              last_word;
    logic              match_c;
    logic [DWIDTH-1:0] nxt_min;
    logic [DWIDTH-1:0] nxt_min2;
    logic [PWIDTH-1:0] nxt_pos;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and FIFO read strobe
    always_comb begin
        state_d       = state_q;
        src_fifo_rden = 1'b0;
        last_word     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (ref_len == '0) ? EMIT : SCAN;
            end
            SCAN: begin
                src_fifo_rden = !src_fifo_empty && (rd_cnt < lat_len);
                last_word = data_vld && (rx_cnt == lat_len - PWIDTH'(1));
                if (last_word) state_d = EMIT;
            end
            EMIT: begin
                if (result_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strict unsigned compare: ties keep the earliest position
    always_comb begin
        nxt_min  = min_q;
        nxt_min2 = min2_q;
        nxt_pos  = pos_q;
        if (data_vld) begin
            if (src_fifo_data < min_q) begin
                nxt_min2 = min_q;
                nxt_min  = src_fifo_data;
                nxt_pos  = rx_cnt;
            end else if (src_fifo_data < min2_q) begin
                nxt_min2 = src_fifo_data;
            end
        end
    end

    // Match decision on the values about to be published
    always_comb begin
        match_c = (nxt_min <= lat_thr);
`ifdef DTW_HIT_MARGIN_EN
        match_c = match_c && ((nxt_min2 - nxt_min) >= lat_margin);
`endif
    end

    // Datapath, counters and registered result record
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running      <= 1'b0;
            result_valid <= 1'b0;
            result_cost  <= ONES;
            result_cost2 <= ONES;
            result_pos   <= '0;
            result_match <= 1'b0;
            lat_len      <= '0;
            lat_thr      <= '0;
`ifdef DTW_HIT_MARGIN_EN
            lat_margin   <= '0;
`endif
            min_q        <= ONES;
            min2_q       <= ONES;
            pos_q        <= '0;
            rd_cnt       <= '0;
            rx_cnt       <= '0;
            data_vld     <= 1'b0;
        end else begin
            data_vld <= src_fifo_rden;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        lat_len <= PWIDTH'(ref_len);
                        lat_thr <= threshold;
`ifdef DTW_HIT_MARGIN_EN
                        lat_margin <= margin;
`endif
                        min_q   <= ONES;
                        min2_q  <= ONES;
                        pos_q   <= '0;
                        rd_cnt  <= '0;
                        rx_cnt  <= '0;
                        running <= 1'b1;
                        if (ref_len == '0) begin
                            result_cost  <= ONES;
                            result_cost2 <= ONES;
                            result_pos   <= '0;
                            result_match <= 1'b0;
                            result_valid <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (src_fifo_rden) rd_cnt <= rd_cnt + PWIDTH'(1);
                    if (data_vld) begin
                        min_q  <= nxt_min;
                        min2_q <= nxt_min2;
                        pos_q  <= nxt_pos;
                        rx_cnt <= rx_cnt + PWIDTH'(1);
                    end
                    if (last_word) begin
                        result_cost  <= nxt_min;
                        result_cost2 <= nxt_min2;
                        result_pos   <= nxt_pos;
                        result_match <= match_c;
                        result_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        running      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/dtw_hit_selector.md
Name: dtw_hit_selector

Overview:
- Downstream consumer of the DTW core's sink FIFO. Reads one 32-bit cost word per reference position and tracks the best (minimum) and second-best cost, plus the position of the best.
- After ref_len words it emits one result record with a match flag against a threshold. Its output goes to the host-facing result register/AXI stage.

Parameters:
- DWIDTH, 32, width of cost words read from the sink FIFO and of all cost outputs.
- PWIDTH, 32, width of the position counter and of result_pos.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a scan; ignored unless in IDLE.
- ref_len  in  32  number of cost words in the scan; sampled on the accepted start.
- threshold  in  DWIDTH  match threshold; sampled on the accepted start.
- running  out  1  high from the accepted start until the result handshake completes.
- src_fifo_rden  out  1  read strobe to the sink FIFO; data is valid on the following cycle.
- src_fifo_empty  in  1  FIFO empty flag.
- src_fifo_data  in  DWIDTH  FIFO read data, registered one cycle after rden.
- result_valid  out  1  result record valid.
- result_ready  in  1  downstream accept.
- result_cost  out  DWIDTH  minimum cost.
- result_pos  out  PWIDTH  zero-based position of the minimum cost.
- result_cost2  out  DWIDTH  second-smallest cost.
- result_match  out  1  match decision.

Behaviour:
- Reset values (async, rst_n low): running=0, src_fifo_rden=0, result_valid=0, result_cost=all-ones, result_cost2=all-ones, result_pos=0, result_match=0. All counters are 0 and the state is IDLE.
- IDLE:
  - start=1 latches ref_len and threshold into lat_len and lat_thr.
  - min and min2 are set to all-ones; rd_cnt, rx_cnt and pos are set to 0; running=1.
  - Next state is SCAN, or EMIT if ref_len==0.
- SCAN:
  - src_fifo_rden = !src_fifo_empty && (rd_cnt < lat_len). This is a combinational output; rd_cnt increments on each rden.
  - The cycle after each rden, src_fifo_data is a valid cost c at position rx_cnt:
    - If c < min: min2<=min, min<=c, pos<=rx_cnt.
    - Else if c < min2: min2<=c.
    - rx_cnt increments.
  - Ties keep the earliest position (strict compare). Comparisons are unsigned.
  - When the last word is received (rx_cnt reaches lat_len-1 in a data cycle), the next state is EMIT. No rden is issued after rd_cnt==lat_len.
  - When empty is high, the scan stalls with no reads and no state change. There is no timeout.
- EMIT:
  - Outputs register result_cost=min, result_cost2=min2, result_pos=pos, result_match=(min <= lat_thr) && (lat_len != 0). result_valid=1.
  - result_valid and all result_* outputs hold stable until result_ready=1.
  - On the handshake cycle: result_valid<=0, running<=0, state returns to IDLE.
  - result_ready while result_valid=0 is ignored.
- Latency: the result is valid 2 cycles after the final rden (data cycle + EMIT register).
- start during SCAN or EMIT is ignored and does not disturb state.
- A single-word scan (ref_len==1) gives min=c, min2=all-ones.
- Reset asserted mid-scan aborts immediately to the reset values. Any in-flight FIFO word is dropped; the FIFO owner flushes separately.
- Widths: position counters are PWIDTH bits. ref_len above 2^PWIDTH-1 is not supported.

Optional Feature:
- Macro DTW_HIT_MARGIN_EN.
- Defined: adds input port margin (DWIDTH, sampled on start). result_match = (min <= lat_thr) && ((min2 - min) >= lat_margin) && (lat_len != 0). The subtraction is unsigned DWIDTH; min2 >= min always holds.
- Undefined: no margin port; match uses the threshold term only.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → all outputs at reset values, no rden pulses.
- Basic scan: ref_len=5, threshold=40, FIFO holds 90,50,30,70,30; result_ready=1 → result_cost=30, result_pos=2 (earliest tie), result_cost2=30, result_match=1; running drops the cycle after the handshake.
- Empty stalls: ref_len=4, costs 10,20,5,8, with src_fifo_empty pulsed high for 1 of every 6 cycles → no rden while empty, exactly 4 rden total; result_cost=5, result_pos=2, result_cost2=8.
- Backpressure and ignored start: hold result_ready=0 for 10 cycles after result_valid and pulse start during that time → outputs stable, the start has no effect, single handshake on ready.
- ref_len=0 → EMIT with no rden, result_cost=all-ones, result_match=0. Also: assert rst_n low mid-SCAN at word 2 of 8 → immediate reset state; a new start then scans cleanly.
- With DTW_HIT_MARGIN_EN, margin=15, threshold=100, costs 40,50 → match=0 (gap 10). Costs 40,60 → match=1.
